// File: rtl/reg_pending_scoreboard.sv
// reg_pending_scoreboard: tracks in-flight register writes and stalls decode on RAW/WAW hazards
module reg_pending_scoreboard #(
  parameter int LAT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_issue_valid,
  input  logic             i_issue_wb,
  input  logic [4:0]       i_issue_rd,
  input  logic [LAT_W-1:0] i_issue_lat,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic             i_rs1_used,
  input  logic             i_rs2_used,
  input  logic             i_flush,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd,
  output logic             o_stall,
  output logic [31:0]      o_busy
);
  logic [31:0]      busy;
  logic [LAT_W-1:0] cnt [32];
  logic             raw_hit, waw_hit, accept;
  // hazard detection from registered state and current decode inputs
  always_comb begin
    raw_hit = (i_rs1_used & |i_rs1 & busy[i_rs1] & |cnt[i_rs1]) |
              (i_rs2_used & |i_rs2 & busy[i_rs2] & |cnt[i_rs2]);
    waw_hit = i_issue_wb & |i_issue_rd & busy[i_issue_rd];
    o_stall = i_issue_valid & ~i_flush & (raw_hit | waw_hit);
    accept  = i_issue_valid & ~i_flush & ~o_stall & i_issue_wb & |i_issue_rd;
    o_busy  = {busy[31:1], 1'b0};
  end
  // per-register update: issue load beats writeback clear beats countdown
  always_ff @(posedge i_clk) begin
    for (int r = 0; r < 32; r++) begin
      if (i_reset || r == 0) begin
        busy[r] <= 1'b0;
        cnt[r]  <= '0;
      end else if (accept && i_issue_rd == 5'(r)) begin
        busy[r] <= 1'b1;
        cnt[r]  <= i_issue_lat;
      end else if (i_wb_valid && i_wb_rd == 5'(r)) begin
        busy[r] <= 1'b0;
        cnt[r]  <= '0;
      end else if (busy[r] && cnt[r] != '0) begin
        cnt[r]  <= cnt[r] - LAT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_reg_pending_scoreboard.sv
// tb_reg_pending_scoreboard: directed stimulus with a queued-expectation monitor
module tb_reg_pending_scoreboard;
  logic        i_clk = 0, i_reset = 1;
  logic        i_issue_valid = 0, i_issue_wb = 0, i_flush = 0, i_wb_valid = 0;
  logic [4:0]  i_issue_rd = 0, i_rs1 = 0, i_rs2 = 0, i_wb_rd = 0;
  logic [2:0]  i_issue_lat = 0;
  logic        i_rs1_used = 0, i_rs2_used = 0;
  logic        o_stall;
  logic [31:0] o_busy;
  typedef struct {string name; logic stall; logic [31:0] busy;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;

  reg_pending_scoreboard #(.LAT_W(3)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_issue_valid(i_issue_valid), .i_issue_wb(i_issue_wb),
    .i_issue_rd(i_issue_rd), .i_issue_lat(i_issue_lat), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used), .i_flush(i_flush),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .o_stall(o_stall), .o_busy(o_busy));

  always #5 i_clk = ~i_clk;

  // monitor: every cycle presents an output; compare against the oldest expectation
  always @(negedge i_clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests += 2;
      if (o_stall !== e.stall) begin
        fails++;
        $display("FAIL %s stall: got %b want %b", e.name, o_stall, e.stall);
      end
      if (o_busy !== e.busy) begin
        fails++;
        $display("FAIL %s busy: got %h want %h", e.name, o_busy, e.busy);
      end
    end
  end

  function automatic logic [31:0] b(input int r);
    return 32'h1 << r;
  endfunction

  task automatic idle();
    i_reset = 0; i_issue_valid = 0; i_issue_wb = 0; i_issue_rd = 0; i_issue_lat = 0;
    i_rs1 = 0; i_rs2 = 0; i_rs1_used = 0; i_rs2_used = 0; i_flush = 0; i_wb_valid = 0; i_wb_rd = 0;
  endtask

  task automatic iss(input logic wb, input logic [4:0] rd, input logic [2:0] lat);
    i_issue_valid = 1; i_issue_wb = wb; i_issue_rd = rd; i_issue_lat = lat;
  endtask

  task automatic src(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    i_rs1 = r1; i_rs1_used = u1; i_rs2 = r2; i_rs2_used = u2;
  endtask

  task automatic wb(input logic [4:0] rd);
    i_wb_valid = 1; i_wb_rd = rd;
  endtask

  task automatic step(input string n, input logic es, input logic [31:0] eb);
    q.push_back('{n, es, eb});
    @(posedge i_clk); #1;
  endtask

  initial begin
    iss(1, 5, 0); wb(5);
    @(posedge i_clk); #1;
    step("rst_a", 0, 0);
    step("rst_b", 0, 0);
    idle(); step("rst_rel", 0, 0);
    iss(1, 7, 2); step("raw_iss", 0, 0);
    idle(); iss(0, 0, 0); src(7, 1, 0, 0);
    step("raw_c1", 1, b(7));
    step("raw_c2", 1, b(7));
    step("raw_c3", 0, b(7));
    idle(); step("raw_hold", 0, b(7));
    wb(7); step("raw_wb", 0, b(7));
    idle(); step("raw_clr", 0, 0);
    iss(1, 0, 3); step("x0_iss", 0, 0);
    idle(); iss(0, 0, 0); src(0, 1, 0, 1); step("x0_rd", 0, 0);
    idle(); iss(1, 3, 4); step("un_iss", 0, 0);
    idle(); iss(0, 0, 0); src(0, 0, 3, 0); step("un_rs2", 0, b(3));
    i_rs2_used = 1; step("un_used", 1, b(3));
    idle(); wb(3); step("un_wb", 0, b(3));
    idle(); step("un_clr", 0, 0);
    iss(1, 9, 0); step("waw_iss", 0, 0);
    idle(); iss(0, 0, 0); src(9, 1, 0, 0); step("waw_fwd", 0, b(9));
    idle(); iss(1, 9, 2); step("waw_st", 1, b(9));
    wb(9); step("waw_wb", 1, b(9));
    idle(); iss(1, 9, 2); step("waw_acc", 0, 0);
    idle(); iss(0, 0, 0); src(9, 1, 0, 0);
    step("waw_r1", 1, b(9));
    step("waw_r2", 1, b(9));
    step("waw_r3", 0, b(9));
    idle(); wb(9); step("waw_wb2", 0, b(9));
    idle(); iss(1, 12, 3); wb(12); step("sim_iss", 0, 0);
    idle(); iss(0, 0, 0); src(0, 0, 12, 1);
    step("sim_r1", 1, b(12));
    step("sim_r2", 1, b(12));
    step("sim_r3", 1, b(12));
    step("sim_r4", 0, b(12));
    idle(); wb(12); step("sim_wb", 0, b(12));
    idle(); iss(1, 4, 5); step("fl_iss", 0, 0);
    iss(1, 4, 1); src(4, 1, 0, 0); i_flush = 1; step("fl_haz", 0, b(4));
    idle(); iss(1, 8, 1); i_flush = 1; step("fl_new", 0, b(4));
    idle(); iss(0, 0, 0); src(4, 1, 0, 0); step("fl_keep", 1, b(4));
    idle(); wb(4); step("fl_wb", 0, b(4));
    idle(); step("fl_clr", 0, 0);
    iss(1, 10, 2); step("mr_iss", 0, 0);
    idle(); i_reset = 1; step("mr_rst", 0, b(10));
    idle(); wb(10); step("mr_after", 0, 0);
    idle(); step("mr_end", 0, 0);
    @(posedge i_clk); #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
